// File: rtl/ripple_count_meter_if.sv
// Control/data bundle between a ripple counter consumer and its controller.
// The master side drives start and the raw counter value; the slave side returns the measurement.
interface ripple_count_meter_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [3:0]       q_in;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             overflow;

  modport master (
    output start,
    output q_in,
    input  busy,
    input  result,
    input  result_valid,
    input  overflow
  );

  modport slave (
    input  start,
    input  q_in,
    output busy,
    output result,
    output result_valid,
    output overflow
  );
endinterface

// File: rtl/ripple_count_meter.sv
// Rate meter for an asynchronous 4-bit ripple counter: synchronizes and filters q_in,
// then sums the count advance over a fixed window of clk cycles with saturation.
module ripple_count_meter #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned GATE_CYCLES = 1000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 clear,
  ripple_count_meter_if.slave bus
);

  localparam int unsigned QW     = 4;
  localparam int unsigned SUM_W  = WIDTH + 1;
  localparam int unsigned GATE_W = $clog2(GATE_CYCLES);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARM     = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;
  localparam logic [1:0] REPORT  = 2'd3;

  logic [SYNC_STAGES-1:0][QW-1:0] sync_q;
  logic [QW-1:0]    s;
  logic [QW-1:0]    p_q;
  logic             stable;

  logic [1:0]       state_q,        state_d;
  logic [QW-1:0]    ref_q,          ref_d;
  logic [WIDTH-1:0] total_q,        total_d;
  logic             ovf_q,          ovf_d;
  logic [GATE_W-1:0] gate_q,        gate_d;
  logic [WIDTH-1:0] result_q,       result_d;
  logic             overflow_q,     overflow_d;
  logic             result_valid_q, result_valid_d;
  logic             busy_q,         busy_d;

  logic [QW-1:0]    delta;
  logic [SUM_W-1:0] sum;
  logic [WIDTH-1:0] acc_total;
  logic             acc_ovf;

  // Synchronizer chain plus one-cycle history used by the stability filter
  always_ff @(posedge clk) begin
    if (clear) begin
      sync_q <= '0;
      p_q    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.q_in};
      p_q    <= s;
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign stable = (s == p_q);

  // 4-bit subtraction wraps naturally across 15 -> 0
  assign delta     = s - ref_q;
  assign sum       = SUM_W'(total_q) + SUM_W'(delta);
  assign acc_total = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  assign acc_ovf   = ovf_q | sum[WIDTH];

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    ref_d          = ref_q;
    total_d        = total_q;
    ovf_d          = ovf_q;
    gate_d         = gate_q;
    result_d       = result_q;
    overflow_d     = overflow_q;
    result_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ARM;
          total_d = '0;
          ovf_d   = 1'b0;
        end
      end
      ARM: begin
        if (stable) begin
          ref_d   = s;
          gate_d  = GATE_W'(GATE_CYCLES - 1);
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (stable) begin
          ref_d   = s;
          total_d = acc_total;
          ovf_d   = acc_ovf;
        end
        // Outputs are loaded on the way into REPORT so the pulse coincides with it
        if (gate_q == '0) begin
          state_d        = REPORT;
          result_d       = total_d;
          overflow_d     = ovf_d;
          result_valid_d = 1'b1;
        end else begin
          gate_d = gate_q - GATE_W'(1);
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q        <= IDLE;
      ref_q          <= '0;
      total_q        <= '0;
      ovf_q          <= 1'b0;
      gate_q         <= '0;
      result_q       <= '0;
      overflow_q     <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ref_q          <= ref_d;
      total_q        <= total_d;
      ovf_q          <= ovf_d;
      gate_q         <= gate_d;
      result_q       <= result_d;
      overflow_q     <= overflow_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_ripple_count_meter.sv
// Bench for ripple_count_meter: three instances with different window/width settings
// share clk, clear and q_in; each measurement is compared with an arithmetic model.
module tb_ripple_count_meter;

  localparam int GA = 20;
  localparam int GB = 40;
  localparam int GC = 80;

  logic clk = 1'b0;
  logic clear;
  logic [3:0] q_drv;

  int checks = 0;
  int fails  = 0;

  logic [3:0] sched[$];

  ripple_count_meter_if #(.WIDTH(16)) bus_a ();
  ripple_count_meter_if #(.WIDTH(16)) bus_b ();
  ripple_count_meter_if #(.WIDTH(4))  bus_c ();

  assign bus_a.q_in = q_drv;
  assign bus_b.q_in = q_drv;
  assign bus_c.q_in = q_drv;

  ripple_count_meter #(.WIDTH(16), .GATE_CYCLES(GA), .SYNC_STAGES(2)) u_a (.clk(clk), .clear(clear), .bus(bus_a));
  ripple_count_meter #(.WIDTH(16), .GATE_CYCLES(GB), .SYNC_STAGES(2)) u_b (.clk(clk), .clear(clear), .bus(bus_b));
  ripple_count_meter #(.WIDTH(4),  .GATE_CYCLES(GC), .SYNC_STAGES(2)) u_c (.clk(clk), .clear(clear), .bus(bus_c));

  always #5 clk = ~clk;

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0:       bus_a.start = v;
      1:       bus_b.start = v;
      default: bus_c.start = v;
    endcase
  endtask

  function automatic logic get_busy(input int inst);
    case (inst)
      0:       return bus_a.busy;
      1:       return bus_b.busy;
      default: return bus_c.busy;
    endcase
  endfunction

  function automatic logic get_rv(input int inst);
    case (inst)
      0:       return bus_a.result_valid;
      1:       return bus_b.result_valid;
      default: return bus_c.result_valid;
    endcase
  endfunction

  function automatic logic [15:0] get_res(input int inst);
    case (inst)
      0:       return bus_a.result;
      1:       return bus_b.result;
      default: return 16'(bus_c.result);
    endcase
  endfunction

  function automatic logic get_ovf(input int inst);
    case (inst)
      0:       return bus_a.overflow;
      1:       return bus_b.overflow;
      default: return bus_c.overflow;
    endcase
  endfunction

  // A counter value counts once it has been seen on two consecutive cycles;
  // the advance between accepted values is taken modulo 16 and saturated at 2^w-1.
  function automatic void model(input logic [3:0] q0, input int w, output int exp_res, output logic exp_ovf);
    logic [3:0] vals[$];
    logic [3:0] prev;
    int sum;
    int maxv;
    vals.push_back(q0);
    vals.push_back(q0);
    foreach (sched[i]) vals.push_back(sched[i]);
    vals.push_back(vals[vals.size()-1]);
    prev = q0;
    sum  = 0;
    for (int i = 1; i < vals.size(); i++) begin
      if (vals[i] == vals[i-1]) begin
        sum += (int'(vals[i]) - int'(prev) + 16) % 16;
        prev = vals[i];
      end
    end
    maxv    = (1 << w) - 1;
    exp_ovf = (sum > maxv);
    exp_res = exp_ovf ? maxv : sum;
  endfunction

  // Starts one window, plays sched into q_in from cycle 4, observes until busy drops
  task automatic run_window(input int inst, input int pre, input int restart_at,
                            output logic busy_first, output int bcount, output int vcount,
                            output int rv_idx, output logic [15:0] res, output logic ovf,
                            output bit tmo);
    int  n;
    bit  done;
    repeat (pre) @(negedge clk);
    set_start(inst, 1'b1);
    @(negedge clk);
    set_start(inst, 1'b0);
    busy_first = get_busy(inst);
    bcount = 0; vcount = 0; rv_idx = -1; res = '0; ovf = 1'b0;
    n = 0; done = 1'b0; tmo = 1'b0;
    while (!done) begin
      if (get_busy(inst)) bcount++;
      if (get_rv(inst)) begin
        vcount++;
        rv_idx = n;
        res    = get_res(inst);
        ovf    = get_ovf(inst);
      end
      if (!get_busy(inst)) begin
        done = 1'b1;
      end else if (n >= 400) begin
        tmo  = 1'b1;
        done = 1'b1;
      end else begin
        if (n >= 4 && (n - 4) < sched.size()) q_drv = sched[n-4];
        set_start(inst, n == restart_at);
        @(negedge clk);
        n++;
      end
    end
    set_start(inst, 1'b0);
  endtask

  task automatic test_reset;
    clear = 1'b1;
    q_drv = 4'd0;
    bus_a.start = 1'b1; bus_b.start = 1'b1; bus_c.start = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus_a.busy !== 1'b0) begin fails++; $display("FAIL reset_busy_a got=%b exp=0", bus_a.busy); end
    checks++; if (bus_a.result !== 16'd0) begin fails++; $display("FAIL reset_result_a got=%0d exp=0", bus_a.result); end
    checks++; if (bus_a.result_valid !== 1'b0) begin fails++; $display("FAIL reset_rv_a got=%b exp=0", bus_a.result_valid); end
    checks++; if (bus_c.overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf_c got=%b exp=0", bus_c.overflow); end
    clear = 1'b0;
    bus_a.start = 1'b0; bus_b.start = 1'b0; bus_c.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({bus_a.busy, bus_b.busy, bus_c.busy} !== 3'b000) begin fails++; $display("FAIL reset_idle_hold got=%b exp=000", {bus_a.busy, bus_b.busy, bus_c.busy}); end
  endtask

  task automatic test_static;
    logic bf, ov; int bc, vc, ri; logic [15:0] r; bit t;
    q_drv = 4'd5;
    sched.delete();
    run_window(0, 6, -1, bf, bc, vc, ri, r, ov, t);
    checks++; if (t !== 1'b0) begin fails++; $display("FAIL static_timeout got=%b exp=0", t); end
    checks++; if (bf !== 1'b1) begin fails++; $display("FAIL static_busy_rise got=%b exp=1", bf); end
    checks++; if (r !== 16'd0) begin fails++; $display("FAIL static_result got=%0d exp=0", r); end
    checks++; if (vc !== 1) begin fails++; $display("FAIL static_rv_count got=%0d exp=1", vc); end
    checks++; if (ri !== GA + 1) begin fails++; $display("FAIL static_rv_cycle got=%0d exp=%0d", ri, GA + 1); end
    checks++; if (bc !== GA + 2) begin fails++; $display("FAIL static_busy_len got=%0d exp=%0d", bc, GA + 2); end
    checks++; if (ov !== 1'b0) begin fails++; $display("FAIL static_ovf got=%b exp=0", ov); end
  endtask

  task automatic test_steady_count;
    logic bf, ov; int bc, vc, ri; logic [15:0] r; bit t;
    q_drv = 4'd3;
    sched.delete();
    for (int k = 1; k <= 5; k++) repeat (4) sched.push_back(4'(3 + k));
    run_window(1, 6, -1, bf, bc, vc, ri, r, ov, t);
    checks++; if (r !== 16'd5) begin fails++; $display("FAIL steady_result got=%0d exp=5", r); end
    checks++; if (bc !== GB + 2) begin fails++; $display("FAIL steady_busy_len got=%0d exp=%0d", bc, GB + 2); end
    checks++; if (vc !== 1 || t !== 1'b0) begin fails++; $display("FAIL steady_rv_count got=%0d tmo=%b exp=1", vc, t); end
  endtask

  task automatic test_wrap_glitch;
    logic bf, ov; int bc, vc, ri; logic [15:0] r; bit t;
    q_drv = 4'd14;
    sched.delete();
    repeat (4) sched.push_back(4'd15);
    repeat (4) sched.push_back(4'd0);
    repeat (4) sched.push_back(4'd1);
    run_window(1, 6, -1, bf, bc, vc, ri, r, ov, t);
    checks++; if (r !== 16'd3) begin fails++; $display("FAIL wrap_result got=%0d exp=3", r); end
    q_drv = 4'd7;
    sched.delete();
    sched.push_back(4'd4);
    repeat (4) sched.push_back(4'd8);
    run_window(1, 6, -1, bf, bc, vc, ri, r, ov, t);
    checks++; if (r !== 16'd1) begin fails++; $display("FAIL glitch_result got=%0d exp=1", r); end
    checks++; if (vc !== 1 || t !== 1'b0) begin fails++; $display("FAIL glitch_rv_count got=%0d tmo=%b exp=1", vc, t); end
  endtask

  task automatic test_clear_abort;
    int pulses;
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    repeat (6) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (bus_b.busy !== 1'b0) begin fails++; $display("FAIL abort_busy got=%b exp=0", bus_b.busy); end
    checks++; if (bus_b.result !== 16'd0) begin fails++; $display("FAIL abort_result got=%0d exp=0", bus_b.result); end
    pulses = 0;
    repeat (GB + 10) begin
      if (bus_b.result_valid === 1'b1 || bus_b.busy === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses !== 0) begin fails++; $display("FAIL abort_no_report got=%0d exp=0", pulses); end
  endtask

  task automatic test_saturation;
    logic bf, ov; int bc, vc, ri; logic [15:0] r; bit t;
    q_drv = 4'd0;
    sched.delete();
    for (int k = 1; k <= 20; k++) repeat (2) sched.push_back(4'(k));
    run_window(2, 6, -1, bf, bc, vc, ri, r, ov, t);
    checks++; if (r !== 16'd15) begin fails++; $display("FAIL sat_result got=%0d exp=15", r); end
    checks++; if (ov !== 1'b1) begin fails++; $display("FAIL sat_ovf got=%b exp=1", ov); end
    sched.delete();
    run_window(2, 4, -1, bf, bc, vc, ri, r, ov, t);
    checks++; if (r !== 16'd0) begin fails++; $display("FAIL sat_next_result got=%0d exp=0", r); end
    checks++; if (ov !== 1'b0) begin fails++; $display("FAIL sat_next_ovf got=%b exp=0", ov); end
  endtask

  task automatic test_start_ignored;
    logic bf, ov; int bc, vc, ri; logic [15:0] r; bit t;
    sched.delete();
    run_window(0, 4, 8, bf, bc, vc, ri, r, ov, t);
    checks++; if (bc !== GA + 2) begin fails++; $display("FAIL restart_busy_len got=%0d exp=%0d", bc, GA + 2); end
    checks++; if (ri !== GA + 1 || vc !== 1) begin fails++; $display("FAIL restart_rv got=%0d/%0d exp=%0d/1", ri, vc, GA + 1); end
    repeat (3) @(negedge clk);
    checks++; if (bus_a.busy !== 1'b0) begin fails++; $display("FAIL restart_not_queued got=%b exp=0", bus_a.busy); end
  endtask

  task automatic test_back_to_back;
    logic bf, ov; int bc, vc, ri; logic [15:0] r; bit t;
    logic [3:0] q0;
    sched.delete();
    run_window(0, 4, -1, bf, bc, vc, ri, r, ov, t);
    q0 = q_drv;
    repeat (3) sched.push_back(q0 + 4'd1);
    repeat (3) sched.push_back(q0 + 4'd2);
    run_window(0, 0, -1, bf, bc, vc, ri, r, ov, t);
    checks++; if (bf !== 1'b1) begin fails++; $display("FAIL b2b_busy_rise got=%b exp=1", bf); end
    checks++; if (r !== 16'd2) begin fails++; $display("FAIL b2b_result got=%0d exp=2", r); end
    checks++; if (ri !== GA + 1 || t !== 1'b0) begin fails++; $display("FAIL b2b_rv_cycle got=%0d exp=%0d", ri, GA + 1); end
  endtask

  task automatic test_random;
    logic bf, ov, eo; int bc, vc, ri, er, inst, w; logic [15:0] r; bit t;
    logic [3:0] q0, v;
    int len;
    for (int it = 0; it < 8; it++) begin
      inst = (it % 2 == 0) ? 1 : 2;
      w    = (inst == 1) ? 16 : 4;
      q0   = q_drv;
      sched.delete();
      for (int sg = 0; sg < int'($urandom_range(3, 7)); sg++) begin
        v   = 4'($urandom_range(0, 15));
        len = int'($urandom_range(1, 4));
        repeat (len) sched.push_back(v);
      end
      model(q0, w, er, eo);
      run_window(inst, 4, -1, bf, bc, vc, ri, r, ov, t);
      checks++; if (r !== 16'(er)) begin fails++; $display("FAIL rand_result it=%0d got=%0d exp=%0d", it, r, er); end
      checks++; if (ov !== eo) begin fails++; $display("FAIL rand_ovf it=%0d got=%b exp=%b", it, ov, eo); end
      checks++; if (vc !== 1 || t !== 1'b0) begin fails++; $display("FAIL rand_rv_count it=%0d got=%0d exp=1", it, vc); end
    end
  endtask

  initial begin
    clear = 1'b1;
    q_drv = 4'd0;
    bus_a.start = 1'b0; bus_b.start = 1'b0; bus_c.start = 1'b0;
    test_reset();
    test_static();
    test_steady_count();
    test_wrap_glitch();
    test_clear_abort();
    test_saturation();
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ripple_count_meter.md
Name: ripple_count_meter

Overview:
- Downstream consumer of the 4-bit ripple counter.
- Samples the counter's asynchronous, ripple-settling output `q` into the system clock domain and filters out transient mid-ripple values.
- Accumulates the count advance over a programmable gate window of `clk` cycles.
- Reports the total as a single-cycle result, with a saturation flag. Used as an event-rate / frequency meter for the counter's input clock.

Parameters:
- WIDTH, 16, width of accumulated result.
- GATE_CYCLES, 1000, measurement window length in `clk` cycles (≥2).
- SYNC_STAGES, 2, synchronizer flop depth on `q_in` (≥2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clear  input  1  synchronous active-high reset.
- start  input  1  one-cycle request to begin a measurement; honoured only in IDLE.
- q_in  input  4  ripple counter output `q[3:0]`, asynchronous to `clk`.
- busy  output  1  high in ARM, MEASURE and REPORT.
- result  output  WIDTH  accumulated count of last completed window.
- result_valid  output  1  one-cycle pulse when `result` updates.
- overflow  output  1  last completed window saturated.

Behaviour:
- Reset (`clear`=1 at a rising edge):
  - state = IDLE.
  - busy, result, result_valid, overflow = 0.
  - Sync flops, prev, ref, total and gate counter = 0.
  - `clear` overrides `start` in the same cycle.
- Synchronizer: `q_in` passes through SYNC_STAGES flops, giving `s`. Register `p` holds the previous `s`.
- Stability filter: `stable` = (`s` == `p`). Only stable samples are used. A value present for one cycle is never accepted.
- Delta: `delta` = (`s` − `ref`) mod 16, computed as a 4-bit subtraction. This handles wrap from 15 to 0.
- Input rate requirement: the counter must advance fewer than 16 counts between consecutive stable samples. Exceeding this undercounts silently.
- FSM states:
  - IDLE: busy=0. If `start`=1 → ARM.
  - ARM:
    - total=0 and internal overflow=0 on entry.
    - Wait for the first `stable` cycle. On it: `ref` <= `s`, gate counter <= GATE_CYCLES−1, → MEASURE.
  - MEASURE:
    - Every `stable` cycle: total += delta, and `ref` <= `s`.
    - If the add exceeds 2^WIDTH−1, total saturates at 2^WIDTH−1 and internal overflow is set (sticky for the window).
    - Gate counter decrements each cycle. When it is 0 in the current cycle (after that cycle's accumulate) → REPORT.
    - MEASURE lasts exactly GATE_CYCLES cycles.
  - REPORT: `result` <= total, `overflow` <= internal overflow, `result_valid`=1 for this one cycle, → IDLE.
- Output timing:
  - `busy` rises the cycle after `start` is sampled.
  - `busy` falls the cycle after REPORT.
  - `result` and `overflow` hold until the next REPORT.
- `start` while busy: ignored, not queued.
- `clear` mid-measurement: aborts. No `result_valid` pulse; `result` is zeroed.
- Back-to-back: `start` in the cycle after REPORT, i.e. in IDLE, is accepted.

Test Plan:
- Reset: `clear`=1 for 2 cycles with `start`=1 → busy=0, result=0, result_valid=0, overflow=0. FSM stays IDLE after `clear` falls and `start` drops.
- Static input: GATE_CYCLES=20, `q_in`=4'd5 constant, pulse `start` → busy=1 next cycle. After ARM plus 20 MEASURE cycles: result=0, result_valid high exactly 1 cycle, overflow=0.
- Steady count: GATE_CYCLES=40, `q_in` steps +1 every 4 cycles from 3. Exactly 5 steps fall inside the window, each ≥SYNC_STAGES+1 cycles from the window edges → result=5.
- Wrap and glitch:
  - `q_in` 14→15→0→1, each held 4 cycles, inside the window → result=3.
  - Separately, 7→4 (1 cycle)→8, held → result=1.
  - Both cases pass only if the glitch is filtered.
- Saturation: WIDTH=4, 20 steps within the window → result=15, overflow=1. The next window with 0 steps gives result=0, overflow=0.
- Control:
  - `start` pulsed mid-MEASURE → ignored; window length unchanged.
  - `clear` asserted mid-MEASURE → no result_valid pulse, busy=0, result=0 next cycle.
